// File: rtl/tx_out_pkg.sv
// Shared definitions for the tx_out serial transmitter.
// Optional even-parity bit is compiled in with `define TX_OUT_PARITY_EN.
package tx_out_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef TX_OUT_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } tx_state_t;

    localparam int DATA_BITS = 8;
`ifdef TX_OUT_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam logic [15:0] DIV_MIN = 16'd2;

    // A divisor below 2 would collapse the bit period; force the minimum.
    function automatic logic [15:0] clamp_div(input logic [15:0] div);
        return (div < DIV_MIN) ? DIV_MIN : div;
    endfunction

endpackage

// File: rtl/tx_out_baud_tick.sv
// baud_tick: loadable down-counter, one-cycle tick on the last clock of each bit period.
module baud_tick (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        load,
    input  logic        en,
    input  logic [15:0] div,
    output logic        tick
);

    logic [15:0] cnt;

    assign tick = en && (cnt == 16'd0);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt <= 16'd0;
        end else if (load || tick) begin
            cnt <= div - 16'd1;
        end else if (en) begin
            cnt <= cnt - 16'd1;
        end
    end

endmodule

// File: rtl/tx_out.sv
// tx_out: processor-port UART transmitter (8N1, or 8E1 with `define TX_OUT_PARITY_EN).
// Divisor register is writable at any time; it is latched per frame at the start bit.
module tx_out
    import tx_out_pkg::*;
#(
    parameter logic [15:0] TX_PORT_ADDR   = 16'h0000,
    parameter logic [15:0] CTRL_PORT_ADDR = 16'h0001,
    parameter int          BAUD_DIV       = 868
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] PORT_ID,
    input  logic [15:0] OUT_PORT,
    input  logic        WRITE_STROBE,
    input  logic        INTERRUPT_ACK,
    output logic        TX,
    output logic        TXRDY,
    output logic        INTERRUPT
);

    localparam logic [15:0] DIV_RESET = clamp_div(16'(BAUD_DIV));

    tx_state_t   state;
    logic [15:0] div_reg;
    logic [15:0] div_lat;
    logic [7:0]  shift;
    logic [2:0]  bit_cnt;
    logic        tx_wr;
    logic        ctrl_wr;
    logic        tick;
    logic        frame_done;
    logic [15:0] tick_div;
`ifdef TX_OUT_PARITY_EN
    logic        par_bit;
`endif

    assign tx_wr      = WRITE_STROBE && (PORT_ID == TX_PORT_ADDR) && (state == ST_IDLE);
    assign ctrl_wr    = WRITE_STROBE && (PORT_ID == CTRL_PORT_ADDR);
    assign frame_done = (state == ST_STOP) && tick;
    // The live register seeds the first bit; the latched copy times the rest of the frame.
    assign tick_div   = (state == ST_IDLE) ? div_reg : div_lat;

    baud_tick u_baud_tick (
        .CLK   (CLK),
        .RESET (RESET),
        .load  (tx_wr),
        .en    (state != ST_IDLE),
        .div   (tick_div),
        .tick  (tick)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= ST_IDLE;
            TX        <= 1'b1;
            TXRDY     <= 1'b1;
            INTERRUPT <= 1'b0;
            div_reg   <= DIV_RESET;
            div_lat   <= DIV_RESET;
            shift     <= 8'd0;
            bit_cnt   <= 3'd0;
`ifdef TX_OUT_PARITY_EN
            par_bit   <= 1'b0;
`endif
        end else begin
            if (ctrl_wr)
                div_reg <= clamp_div(OUT_PORT);

            // Frame completion outranks a coincident acknowledge.
            if (frame_done)
                INTERRUPT <= 1'b1;
            else if (INTERRUPT_ACK)
                INTERRUPT <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (tx_wr) begin
                        state   <= ST_START;
                        TX      <= 1'b0;
                        TXRDY   <= 1'b0;
                        shift   <= OUT_PORT[7:0];
                        div_lat <= div_reg;
                        bit_cnt <= 3'd0;
`ifdef TX_OUT_PARITY_EN
                        par_bit <= ^OUT_PORT[7:0];
`endif
                    end
                end
                ST_START: begin
                    if (tick) begin
                        state <= ST_DATA;
                        TX    <= shift[0];
                        shift <= shift >> 1;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_cnt == 3'(DATA_BITS - 1)) begin
`ifdef TX_OUT_PARITY_EN
                            state <= ST_PARITY;
                            TX    <= par_bit;
`else
                            state <= ST_STOP;
                            TX    <= 1'b1;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            TX      <= shift[0];
                            shift   <= shift >> 1;
                        end
                    end
                end
`ifdef TX_OUT_PARITY_EN
                ST_PARITY: begin
                    if (tick) begin
                        state <= ST_STOP;
                        TX    <= 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (tick) begin
                        state <= ST_IDLE;
                        TXRDY <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    TX    <= 1'b1;
                    TXRDY <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_out.sv
// Directed bench for tx_out at BAUD_DIV=4; outputs are sampled on the falling edge.
module tb_tx_out;

    logic        CLK;
    logic        RESET;
    logic [15:0] PORT_ID;
    logic [15:0] OUT_PORT;
    logic        WRITE_STROBE;
    logic        INTERRUPT_ACK;
    logic        TX;
    logic        TXRDY;
    logic        INTERRUPT;

    int vectors    = 0;
    int miscompares = 0;

    tx_out #(
        .TX_PORT_ADDR   (16'h0000),
        .CTRL_PORT_ADDR (16'h0001),
        .BAUD_DIV       (4)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .PORT_ID       (PORT_ID),
        .OUT_PORT      (OUT_PORT),
        .WRITE_STROBE  (WRITE_STROBE),
        .INTERRUPT_ACK (INTERRUPT_ACK),
        .TX            (TX),
        .TXRDY         (TXRDY),
        .INTERRUPT     (INTERRUPT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

`ifdef TX_OUT_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Called at a falling edge; leaves the bench at the falling edge after the strobe is taken.
    task automatic strobe(input logic [15:0] port, input logic [15:0] data);
        PORT_ID      = port;
        OUT_PORT     = data;
        WRITE_STROBE = 1'b1;
        @(negedge CLK);
        WRITE_STROBE = 1'b0;
    endtask

    task automatic ack_pulse();
        INTERRUPT_ACK = 1'b1;
        @(negedge CLK);
        INTERRUPT_ACK = 1'b0;
        chk("ack_clears_irq", {15'd0, INTERRUPT}, 16'd1 - 16'd1);
    endtask

    // Checks a whole frame starting at cycle 1 (the falling edge right after the accepting strobe).
    // inj_kind: 0 none, 1 port write, 2 interrupt ack; driven at cycle inj_cycle.
    task automatic run_frame(input logic [7:0] data, input int div, input logic irq_during,
                             input int inj_cycle, input int inj_kind,
                             input logic [15:0] inj_port, input logic [15:0] inj_data);
        logic bits [NBITS];
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = data[i];
`ifdef TX_OUT_PARITY_EN
        bits[9] = ^data;
`endif
        bits[NBITS-1] = 1'b1;
        for (int c = 1; c <= NBITS*div; c++) begin
            chk($sformatf("tx_d%02h_c%0d", data, c), {15'd0, TX}, {15'd0, bits[(c-1)/div]});
            chk($sformatf("txrdy_d%02h_c%0d", data, c), {15'd0, TXRDY}, 16'd0);
            chk($sformatf("irq_d%02h_c%0d", data, c), {15'd0, INTERRUPT}, {15'd0, irq_during});
            if (c == inj_cycle && inj_kind == 1) begin
                PORT_ID = inj_port; OUT_PORT = inj_data; WRITE_STROBE = 1'b1;
            end
            if (c == inj_cycle && inj_kind == 2) INTERRUPT_ACK = 1'b1;
            @(negedge CLK);
            WRITE_STROBE  = 1'b0;
            INTERRUPT_ACK = 1'b0;
        end
        chk($sformatf("end_tx_d%02h", data), {15'd0, TX}, 16'd1);
        chk($sformatf("end_txrdy_d%02h", data), {15'd0, TXRDY}, 16'd1);
        chk($sformatf("end_irq_d%02h", data), {15'd0, INTERRUPT}, 16'd1);
    endtask

    task automatic idle_check(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_tx_%0d", tag, i), {15'd0, TX}, 16'd1);
            chk($sformatf("%s_txrdy_%0d", tag, i), {15'd0, TXRDY}, 16'd1);
            @(negedge CLK);
        end
    endtask

    initial begin
        RESET = 1'b1; PORT_ID = 16'h0; OUT_PORT = 16'h0;
        WRITE_STROBE = 1'b0; INTERRUPT_ACK = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_tx",    {15'd0, TX},        16'd1);
        chk("rst_txrdy", {15'd0, TXRDY},     16'd1);
        chk("rst_irq",   {15'd0, INTERRUPT}, 16'd0);
        RESET = 1'b0;
        @(negedge CLK);

        // Basic 0x55 frame, 40 clocks.
        strobe(16'h0000, 16'h0055);
        run_frame(8'h55, 4, 1'b0, 0, 0, 16'h0, 16'h0);
        @(negedge CLK);
        chk("irq_level_held", {15'd0, INTERRUPT}, 16'd1);
        ack_pulse();

        // Data write at clock 12 is dropped; no second frame follows.
        strobe(16'h0000, 16'h0055);
        run_frame(8'h55, 4, 1'b0, 12, 1, 16'h0000, 16'h00AA);
        idle_check("no_second_frame", 50);
        chk("single_irq_held", {15'd0, INTERRUPT}, 16'd1);
        ack_pulse();

        // Ack on the frame-completing edge: set wins.
        strobe(16'h0000, 16'h0055);
        run_frame(8'h55, 4, 1'b0, NBITS*4, 2, 16'h0, 16'h0);
        ack_pulse();

        // Divisor change mid-frame applies to the next, back-to-back frame only.
        strobe(16'h0000, 16'h00A5);
        run_frame(8'hA5, 4, 1'b0, 10, 1, 16'h0001, 16'h0008);
        strobe(16'h0000, 16'h003C);
        run_frame(8'h3C, 8, 1'b1, 0, 0, 16'h0, 16'h0);
        ack_pulse();

        // Divisor 0 clamps to 2; write to unmapped port is ignored.
        strobe(16'h0001, 16'h0000);
        strobe(16'h0005, 16'h0012);
        chk("unmapped_txrdy", {15'd0, TXRDY}, 16'd1);
        chk("unmapped_tx",    {15'd0, TX},    16'd1);
        strobe(16'h0000, 16'h0081);
        run_frame(8'h81, 2, 1'b0, 0, 0, 16'h0, 16'h0);

        // Asynchronous reset mid-frame, interrupt pending.
        strobe(16'h0000, 16'h0055);
        for (int i = 0; i < 6; i++) @(negedge CLK);
        chk("pre_rst_txrdy", {15'd0, TXRDY}, 16'd0);
        #2 RESET = 1'b1;
        #1;
        chk("async_rst_tx",    {15'd0, TX},        16'd1);
        chk("async_rst_txrdy", {15'd0, TXRDY},     16'd1);
        chk("async_rst_irq",   {15'd0, INTERRUPT}, 16'd0);
        #1 RESET = 1'b0;
        @(negedge CLK);
        idle_check("no_resume", 30);
        chk("no_resume_irq", {15'd0, INTERRUPT}, 16'd0);

        // Divisor back to reset value of 4.
        strobe(16'h0000, 16'h00C3);
        run_frame(8'hC3, 4, 1'b0, 0, 0, 16'h0, 16'h0);
        ack_pulse();

`ifdef TX_OUT_PARITY_EN
        strobe(16'h0000, 16'h0007);
        run_frame(8'h07, 4, 1'b0, 0, 0, 16'h0, 16'h0);
        ack_pulse();
        strobe(16'h0000, 16'h0003);
        run_frame(8'h03, 4, 1'b0, 0, 0, 16'h0, 16'h0);
        ack_pulse();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tx_out.md
TX_OUT -- requirements
Module: tx_out

Interface
REQ-001 SHALL have parameter TX_PORT_ADDR, default 16'h0000, PORT_ID value selecting the transmit-data register.
REQ-002 SHALL have parameter CTRL_PORT_ADDR, default 16'h0001, PORT_ID value selecting the baud-divisor register.
REQ-003 SHALL have parameter BAUD_DIV, default 868, reset value of the divisor in clocks per bit (115200 baud at 100 MHz).
REQ-004 SHALL have port CLK  input  1  system clock, all state on rising edge.
REQ-005 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port PORT_ID  input  16  processor port address.
REQ-007 SHALL have port OUT_PORT  input  16  processor write data.
REQ-008 SHALL have port WRITE_STROBE  input  1  one-cycle processor write qualifier.
REQ-009 SHALL have port INTERRUPT_ACK  input  1  processor interrupt acknowledge.
REQ-010 SHALL have port TX  output  1  serial line, idle high.
REQ-011 SHALL have port TXRDY  output  1  high when transmitter idle and able to accept a byte.
REQ-012 SHALL have port INTERRUPT  output  1  level interrupt to processor, set on frame completion.

Function
REQ-013 SHALL accept a byte when WRITE_STROBE=1, PORT_ID=TX_PORT_ADDR and TXRDY=1, latching OUT_PORT[7:0].
REQ-014 SHALL ignore data writes while TXRDY=0: no queueing, no corruption of the frame in progress.
REQ-015 SHALL ignore writes to any PORT_ID other than TX_PORT_ADDR and CTRL_PORT_ADDR.
REQ-016 SHALL on the clock edge that accepts a byte drop TXRDY and drive TX low (start bit), both registered, visible the cycle after the strobe.
REQ-017 SHALL implement states IDLE, START, DATA, PARITY, STOP; IDLE->START on accept, START->DATA, DATA->DATA for 8 bits LSB first, DATA->PARITY (if enabled) or STOP, STOP->IDLE.
REQ-018 SHALL hold every bit for exactly the latched divisor count of clocks; frame length 10*div clocks (11*div with parity).
REQ-019 SHALL latch the divisor at frame start; a CTRL_PORT_ADDR write mid-frame takes effect on the next frame only.
REQ-020 SHALL load the divisor from OUT_PORT[15:0] on a CTRL_PORT_ADDR write regardless of TXRDY; values 0 and 1 clamp to 2.
REQ-021 SHALL raise TXRDY and set INTERRUPT on the cycle after the last STOP-bit clock; TX stays high.
REQ-022 SHALL clear INTERRUPT on the cycle after INTERRUPT_ACK=1; set and ack on the same edge leave INTERRUPT=1 (set wins).
REQ-023 SHALL accept a new byte on the first cycle TXRDY=1, giving back-to-back frames with no idle gap beyond one clock.

Reset
REQ-024 SHALL on RESET=1, immediately and independent of CLK, force TX=1, TXRDY=1, INTERRUPT=0, state IDLE, divisor=BAUD_DIV, counters 0.
REQ-025 SHALL abort any frame in progress on reset; no partial frame resumes after release.

Configuration
REQ-026 SHALL, with macro TX_OUT_PARITY_EN defined, insert an even-parity bit (XOR of the 8 data bits) between data and stop, one divisor long.
REQ-027 SHALL, without TX_OUT_PARITY_EN, omit the PARITY state and its logic entirely; frame is 8N1.

Structure
REQ-028 SHALL place the state enumeration, frame bit counts and divisor minimum (2) in shared package tx_out_pkg.
REQ-029 SHALL use one sub-module, baud_tick, a loadable down-counter issuing a one-cycle bit-period tick.

Verification (BAUD_DIV=4)
REQ-030 SHALL check: reset, write 16'h0055 to port 0 -> TX 0,1,0,1,0,1,0,1,0,1 each 4 clocks, TXRDY low 40 clocks, INTERRUPT rises with TXRDY.
REQ-031 SHALL check: write 16'h00AA to port 0 at clock 12 of a 0x55 frame -> frame unchanged, no second frame, one INTERRUPT.
REQ-032 SHALL check: INTERRUPT_ACK pulse -> INTERRUPT 0 next cycle; ack coincident with frame end -> INTERRUPT stays 1.
REQ-033 SHALL check: write 16'h0008 to port 1 mid-frame -> current bits 4 clocks, next frame bits 8 clocks; write 16'h0000 -> bits 2 clocks.
REQ-034 SHALL check: RESET pulse mid-frame between clock edges -> TX=1, TXRDY=1, INTERRUPT=0 before next edge; no resumption.
REQ-035 SHALL check with TX_OUT_PARITY_EN: write 16'h0007 -> parity bit 1, frame 44 clocks; 16'h0003 -> parity bit 0.
